// File: rtl/inst_encoder_loader_if.sv
// Symbolic-instruction input stream and instruction-memory write port of the encoder/loader.
// The slave modport is the loader's view; master is the view of whoever feeds it and owns the memory.
interface inst_encoder_loader_if #(
    parameter int AW   = 8,
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_mn;
    logic            in_byte;
    logic [4:0]      in_ra;
    logic [4:0]      in_rb;
    logic [4:0]      in_rd;
    logic [10:0]     in_imm;
    logic            in_last;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    modport slave (
        input  in_valid, in_mn, in_byte, in_ra, in_rb, in_rd, in_imm, in_last, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_mn, in_byte, in_ra, in_rb, in_rd, in_imm, in_last, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes symbolic instructions into 32-bit core words and streams them into instruction memory,
// with start/last/done session sequencing, address/word counting and a sticky error flag.
module inst_encoder_loader #(
    parameter int XLEN      = 32,
    parameter int AW        = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    inst_encoder_loader_if.slave   bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [AW:0]            count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [AW-1:0] BASE_C   = AW'(BASE_ADDR);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

    state_e          state_q, state_d;
    logic            wr_valid_q, wr_valid_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            last_seen_q, last_seen_d;
    logic            in_ready_s;
    logic            accept_s;
    logic            fire_s;
    logic            illegal_s;
    logic [AW:0]     pending_s;

    // Branch mnemonics share opcode 13 and carry their condition in the rd field.
    function automatic logic [31:0] encode(
        input logic [4:0]  mn,
        input logic        byt,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [4:0]  rd,
        input logic [10:0] imm
    );
        logic [5:0] opc;
        logic [4:0] rdf;
        opc = {1'b0, mn};
        rdf = rd;
        case (mn)
            5'd11, 5'd12: opc = {byt, mn};
            5'd13: begin opc = 6'd13; rdf = 5'd0; end
            5'd14: begin opc = 6'd13; rdf = 5'd1; end
            5'd15: begin opc = 6'd13; rdf = 5'd2; end
            5'd16: begin opc = 6'd13; rdf = 5'd3; end
            5'd17: opc = 6'd14;
            default: opc = {1'b0, mn};
        endcase
        return {opc, ra, rb, rdf, imm};
    endfunction

    // Next-state, write-register and handshake logic.
    always_comb begin
        state_d     = state_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        count_d     = count_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        in_ready_s  = 1'b0;
        accept_s    = 1'b0;
        fire_s      = wr_valid_q && bus.wr_ready;
        illegal_s   = (bus.in_mn > 5'd17);
        pending_s   = {{AW{1'b0}}, wr_valid_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_LOAD;
                    wr_addr_d   = BASE_C;
                    count_d     = {(AW+1){1'b0}};
                    err_d       = 1'b0;
                    last_seen_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The pending word counts against the session budget so DEPTH is never exceeded.
                in_ready_s = (!wr_valid_q || bus.wr_ready) && !last_seen_q
                             && ((count_q + pending_s) < DEPTH_C);
                accept_s   = bus.in_valid && in_ready_s;

                if (fire_s) begin
                    wr_addr_d  = wr_addr_q + ADDR_ONE;
                    count_d    = count_q + CNT_ONE;
                    wr_valid_d = 1'b0;
                end else begin
                    wr_valid_d = wr_valid_q;
                end

                if (accept_s) begin
                    last_seen_d = bus.in_last;
                    if (illegal_s) begin
                        err_d = 1'b1;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = encode(bus.in_mn, bus.in_byte, bus.in_ra,
                                            bus.in_rb, bus.in_rd, bus.in_imm);
                    end
                end else begin
                    last_seen_d = last_seen_q;
                end

                if (last_seen_q && (!wr_valid_q || bus.wr_ready)) begin
                    state_d = ST_DONE;
                end else if (!last_seen_q && !wr_valid_q && (count_q == DEPTH_C)
                             && bus.in_valid) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= BASE_C;
            wr_data_q   <= {XLEN{1'b0}};
            count_q     <= {(AW+1){1'b0}};
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy_o       = (state_q == ST_LOAD);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: vector table, directed corner sequences and
// randomized sessions checked against an arithmetic encoding/session model.
module tb_inst_encoder_loader;
    localparam int AW    = 8;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          busy_o, done_o, err_o;
    logic [AW:0]   count_o;

    always #5 clk = ~clk;

    inst_encoder_loader_if #(.AW(AW), .XLEN(XLEN)) bus();

    inst_encoder_loader #(.XLEN(XLEN), .AW(AW), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bus(bus.slave),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit rnd_ready = 1'b0;
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    typedef struct {
        logic [4:0]  mn;
        logic        byt;
        logic [4:0]  ra, rb, rd;
        logic [10:0] imm;
        logic        legal;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[11];

    // Write and done-pulse monitor.
    always @(posedge clk) begin
        if (!rst && bus.wr_valid && bus.wr_ready) begin
            got_addr.push_back(bus.wr_addr);
            got_data.push_back(bus.wr_data);
        end
        if (!rst && done_o) done_cnt <= done_cnt + 1;
    end

    // Random memory back-pressure.
    always @(negedge clk) begin
        if (rnd_ready) bus.wr_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_enc(input int mn, input int byt, input int ra,
                                              input int rb, input int rd, input int imm);
        longint opc, r;
        r = rd;
        if (mn <= 12) opc = mn;
        else if (mn == 17) opc = 14;
        else begin opc = 13; r = mn - 13; end
        if ((mn == 11 || mn == 12) && byt != 0) opc = opc + 32;
        return 32'(opc * 64'd67108864 + ra * 64'd2097152 + rb * 64'd65536 + r * 64'd2048 + imm);
    endfunction

    task automatic do_start();
        got_addr.delete();
        got_data.delete();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic drive(input logic [4:0] mn, input logic byt, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] rd, input logic [10:0] imm,
                         input logic last);
        bus.in_mn = mn; bus.in_byte = byt; bus.in_ra = ra; bus.in_rb = rb;
        bus.in_rd = rd; bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [4:0] mn, input logic byt, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] rd, input logic [10:0] imm,
                        input logic last);
        int k;
        drive(mn, byt, ra, rb, rd, imm, last);
        #1;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("accept_timeout", 64'(k), 64'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_done"}, 64'(done_o), 64'(1));
        @(negedge clk);
        check({nm, "_busy_after"}, 64'(busy_o), 64'(0));
        check({nm, "_done_one_cycle"}, 64'(done_o), 64'(0));
    endtask

    initial begin
        int dc;
        // ADD SUB ST/byte ST JMP BGT MUL ADDI BLT and two illegal codes
        tbl[0]  = '{5'd0,  1'b0, 5'd1,  5'd2, 5'd3,  11'h000, 1'b1, 32'h00221800};
        tbl[1]  = '{5'd1,  1'b1, 5'd31, 5'd0, 5'd0,  11'h7FF, 1'b1, 32'h07E007FF};
        tbl[2]  = '{5'd12, 1'b1, 5'd1,  5'd2, 5'd3,  11'h005, 1'b1, 32'hB0221805};
        tbl[3]  = '{5'd12, 1'b0, 5'd1,  5'd2, 5'd3,  11'h005, 1'b1, 32'h30221805};
        tbl[4]  = '{5'd13, 1'b0, 5'd0,  5'd0, 5'd31, 11'h123, 1'b1, 32'h34000123};
        tbl[5]  = '{5'd16, 1'b1, 5'd0,  5'd0, 5'd0,  11'h000, 1'b1, 32'h34001800};
        tbl[6]  = '{5'd17, 1'b0, 5'd1,  5'd1, 5'd1,  11'h001, 1'b1, 32'h38210801};
        tbl[7]  = '{5'd8,  1'b1, 5'd0,  5'd0, 5'd2,  11'h400, 1'b1, 32'h20001400};
        tbl[8]  = '{5'd15, 1'b0, 5'd3,  5'd0, 5'd0,  11'h007, 1'b1, 32'h34601007};
        tbl[9]  = '{5'd18, 1'b0, 5'd1,  5'd1, 5'd1,  11'h001, 1'b0, 32'h00000000};
        tbl[10] = '{5'd31, 1'b1, 5'd2,  5'd2, 5'd2,  11'h002, 1'b0, 32'h00000000};

        // Reset with live inputs
        rst = 1'b1; start_i = 1'b0;
        drive(5'd0, 1'b0, 5'd1, 5'd2, 5'd3, 11'd0, 1'b1);
        bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_count",    64'(count_o), 64'(0));
        check("rst_err",      64'(err_o), 64'(0));
        check("rst_busy",     64'(busy_o), 64'(0));
        check("rst_addr",     64'(bus.wr_addr), 64'(0));
        check("rst_data",     64'(bus.wr_data), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'(0));
        check("idle_no_write", 64'(got_data.size()), 64'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Vector table: one single-instruction session per entry
        for (int i = 0; i < 11; i++) begin
            dc = done_cnt;
            do_start();
            send(tbl[i].mn, tbl[i].byt, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].imm, 1'b1);
            wait_done("tbl");
            check("tbl_done_pulses", 64'(done_cnt), 64'(dc + 1));
            check("tbl_nwrites", 64'(got_data.size()), tbl[i].legal ? 64'(1) : 64'(0));
            check("tbl_err",     64'(err_o), tbl[i].legal ? 64'(0) : 64'(1));
            check("tbl_count",   64'(count_o), tbl[i].legal ? 64'(1) : 64'(0));
            if (got_data.size() > 0) begin
                check("tbl_data", 64'(got_data[0]), 64'(tbl[i].exp));
                check("tbl_addr", 64'(got_addr[0]), 64'(0));
            end
        end

        // BEQ then byte LD
        do_start();
        send(5'd14, 1'b0, 5'd4, 5'd5, 5'd9, 11'h010, 1'b0);
        send(5'd11, 1'b1, 5'd2, 5'd0, 5'd7, 11'h004, 1'b1);
        wait_done("beq_ld");
        check("beq_ld_n", 64'(got_data.size()), 64'(2));
        if (got_data.size() == 2) begin
            check("beq_data", 64'(got_data[0]), 64'h34850810);
            check("ld_data",  64'(got_data[1]), 64'hAC403804);
            check("ld_addr",  64'(got_addr[1]), 64'(1));
        end
        check("beq_ld_count", 64'(count_o), 64'(2));

        // Stall: wr_ready low for 3 cycles during a 3-instruction burst
        do_start();
        bus.wr_ready = 1'b0;
        send(5'd0, 1'b0, 5'd1, 5'd2, 5'd3, 11'd0, 1'b0);
        drive(5'd1, 1'b0, 5'd4, 5'd5, 5'd6, 11'd7, 1'b0);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_wr_valid", 64'(bus.wr_valid), 64'(1));
            check("stall_wr_data",  64'(bus.wr_data), 64'h00221800);
            check("stall_wr_addr",  64'(bus.wr_addr), 64'(0));
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        bus.wr_ready = 1'b1;
        send(5'd1, 1'b0, 5'd4, 5'd5, 5'd6, 11'd7, 1'b0);
        send(5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 11'h7FF, 1'b1);
        wait_done("stall");
        check("stall_n", 64'(got_data.size()), 64'(3));
        if (got_data.size() == 3) begin
            check("stall_d0", 64'(got_data[0]), 64'h00221800);
            check("stall_d1", 64'(got_data[1]), 64'h04853007);
            check("stall_d2", 64'(got_data[2]), 64'h0C0007FF);
            check("stall_a2", 64'(got_addr[2]), 64'(2));
        end
        check("stall_count", 64'(count_o), 64'(3));

        // Illegal mnemonic followed by SUB with last
        do_start();
        send(5'd20, 1'b0, 5'd1, 5'd1, 5'd1, 11'd1, 1'b0);
        send(5'd1, 1'b0, 5'd1, 5'd1, 5'd1, 11'd0, 1'b1);
        wait_done("illegal");
        check("illegal_err", 64'(err_o), 64'(1));
        check("illegal_n", 64'(got_data.size()), 64'(1));
        if (got_data.size() == 1) begin
            check("illegal_sub_data", 64'(got_data[0]), 64'h04210800);
            check("illegal_sub_addr", 64'(got_addr[0]), 64'(0));
        end
        check("illegal_count", 64'(count_o), 64'(1));
        do_start();
        check("start_clears_err", 64'(err_o), 64'(0));
        send(5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 11'd0, 1'b1);
        wait_done("clear");

        // Overflow: DEPTH+1 instructions without last
        dc = done_cnt;
        do_start();
        for (int i = 0; i < DEPTH; i++) send(5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 11'(i), 1'b0);
        drive(5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 11'd99, 1'b0);
        wait_done("ovf");
        bus.in_valid = 1'b0;
        check("ovf_n", 64'(got_data.size()), 64'(DEPTH));
        if (got_data.size() == DEPTH) begin
            check("ovf_last_data", 64'(got_data[DEPTH-1]), 64'(DEPTH - 1));
            check("ovf_last_addr", 64'(got_addr[DEPTH-1]), 64'(DEPTH - 1));
        end
        check("ovf_err", 64'(err_o), 64'(1));
        check("ovf_count", 64'(count_o), 64'(DEPTH));
        check("ovf_done_pulses", 64'(done_cnt), 64'(dc + 1));

        // Reset mid-session with a pending write
        do_start();
        bus.wr_ready = 1'b0;
        send(5'd2, 1'b0, 5'd1, 5'd1, 5'd1, 11'd1, 1'b0);
        check("pre_rst_wr_valid", 64'(bus.wr_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("midrst_wr_valid", 64'(bus.wr_valid), 64'(0));
        check("midrst_busy",     64'(busy_o), 64'(0));
        check("midrst_count",    64'(count_o), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_write", 64'(got_data.size()), 64'(0));
        check("midrst_idle", 64'(busy_o), 64'(0));

        // Randomized sessions against the model
        for (int s = 0; s < 40; s++) begin
            int n, k, exp_n;
            bit ovf, exp_err;
            int mn[6], by[6], ra[6], rb[6], rd[6], im[6];
            logic [31:0] exp_q[$];
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                mn[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 31) : $urandom_range(0, 17);
                by[i] = $urandom_range(0, 1);
                ra[i] = $urandom_range(0, 31);
                rb[i] = $urandom_range(0, 31);
                rd[i] = $urandom_range(0, 31);
                im[i] = $urandom_range(0, 2047);
            end
            exp_q.delete();
            exp_n = 0; k = 0; ovf = 1'b0; exp_err = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (exp_n == DEPTH) begin
                    ovf = 1'b1; exp_err = 1'b1;
                    break;
                end
                k++;
                if (mn[i] > 17) exp_err = 1'b1;
                else begin
                    exp_q.push_back(model_enc(mn[i], by[i], ra[i], rb[i], rd[i], im[i]));
                    exp_n++;
                end
            end
            dc = done_cnt;
            do_start();
            rnd_ready = 1'b1;
            for (int i = 0; i < k; i++)
                send(5'(mn[i]), 1'(by[i]), 5'(ra[i]), 5'(rb[i]), 5'(rd[i]), 11'(im[i]),
                     (i == n - 1) ? 1'b1 : 1'b0);
            if (ovf) drive(5'(mn[k]), 1'(by[k]), 5'(ra[k]), 5'(rb[k]), 5'(rd[k]), 11'(im[k]), 1'b0);
            wait_done("rnd");
            bus.in_valid = 1'b0;
            rnd_ready = 1'b0;
            bus.wr_ready = 1'b1;
            check("rnd_n", 64'(got_data.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
                check("rnd_data", 64'(got_data[i]), 64'(exp_q[i]));
                check("rnd_addr", 64'(got_addr[i]), 64'(i));
            end
            check("rnd_err", 64'(err_o), 64'(exp_err));
            check("rnd_count", 64'(count_o), 64'(exp_n));
            check("rnd_done_pulses", 64'(done_cnt), 64'(dc + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the pipeline's instruction decoder.
- Accepts symbolic instructions (mnemonic plus register and immediate fields) over a valid/ready stream.
- Encodes each into the 32-bit core instruction format and writes it sequentially into instruction memory through a handshaked write port.
- Used by the testbench and the boot path to load programs before the core leaves reset-hold. Provides start/last/done sequencing, address counting and error reporting.

Parameters:
- XLEN, 32, instruction word width; the field layout requires 32.
- AW, 8, instruction memory address width (word addresses).
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, maximum words per load session; must be at most 2**AW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept.
- in_mn  in  5  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 ADDI, 9 LT, 10 GT, 11 LD, 12 ST, 13 JMP, 14 BEQ, 15 BLT, 16 BGT, 17 MUL; 18-31 are illegal.
- in_byte  in  1  byte access; only honoured for LD/ST.
- in_ra, in_rb, in_rd  in  5 each  register fields.
- in_imm  in  11  immediate.
- in_last  in  1  marks the final instruction of the session.
- wr_valid  out  1  write request to instruction memory.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  AW  word address.
- wr_data  out  XLEN  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error; cleared by start.
- count  out  AW+1  words written in the current session.

Behaviour:
- Reset (async): state IDLE; in_ready=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, count=0.
- States and transitions:
  - IDLE: start -> LOAD; sets wr_addr=BASE_ADDR, count=0, err=0.
  - LOAD: busy=1.
    - in_ready = !wr_valid || wr_ready, and the last instruction has not yet been accepted, and count plus pending writes < DEPTH.
    - When in_last has been accepted and its write completes -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start while in LOAD is ignored.
- Encoding layout: [31:26] opc, [25:21] ra, [20:16] rb, [15:11] rd, [10:0] imm.
  - Mnemonics 0-12: opc = mn.
  - MUL: opc = 14.
  - JMP/BEQ/BLT/BGT: opc = 13; rd field forced to 0/1/2/3 respectively; in_rd is ignored.
  - LD/ST with in_byte=1: opc[5]=1. For every other mnemonic, opc[5]=0 regardless of in_byte.
- Timing and pipeline:
  - Latency 1: the word accepted at edge N appears on wr_data/wr_valid after edge N.
  - Single output register. wr_valid holds and wr_data/wr_addr stay stable until wr_ready.
  - Back-to-back throughput is 1/cycle while wr_ready stays high.
- Address and count update: on each completed write (wr_valid && wr_ready), wr_addr increments (wraps modulo 2**AW) and count increments.
- Illegal mnemonic:
  - The instruction is accepted but not written, and err is set.
  - If it carried in_last, the session still ends via DONE once any pending write drains.
- Overflow: an in_valid held while count has reached DEPTH without a prior last sets err and ends the session via DONE. No write is issued.
- Simultaneous acceptance of a new input and completion of the pending write is legal and gives no bubble.
- Reset asserted mid-session aborts immediately. Any pending write is dropped (wr_valid=0 asynchronously).

Test Plan:
- Reset with in_valid=1, wr_ready=1 -> wr_valid=0, in_ready=0, count=0, err=0; no writes.
- start; ADD ra=1 rb=2 rd=3 imm=0 with last -> one write, addr 0x00, data 0x00221800; count=1; done pulses once; busy returns to 0.
- start; BEQ ra=4 rb=5 rd=9 imm=0x010; then LD byte ra=2 rd=7 imm=4 with last -> addr0 0x34850810 (rd forced to 1), addr1 0xAC403804; count=2.
- wr_ready held low 3 cycles during a 3-instruction burst -> wr_valid/wr_data/wr_addr stable, in_ready=0 while stalled; after release, all 3 words are written in order at addresses 0, 1, 2 with no loss or duplication.
- mn=20 followed by SUB with last -> err=1; only SUB is written, at addr 0; count=1; next start clears err.
- DEPTH=4 build, 5 instructions without last -> 4 writes, err=1, done pulse, 5th instruction never written; rst asserted mid-burst -> wr_valid drops immediately, state IDLE.
